// File: rtl/bp_be_mem_fault_pipe_if.sv
// Request/response bundle for the BE memory fault-staging pipe.
// Latency: n/a (wiring only); backpressure: ready_o is the only stall signal toward the requester.
// Ports: control (flush/hold/cnt_clear), stage-0 request, stage-1 late faults, retire outputs.
interface bp_be_mem_fault_pipe_if #(
  parameter int eaddr_width_p = 64,
  parameter int vaddr_width_p = 39,
  parameter int cnt_width_p   = 16
);
  logic                     flush_i;
  logic                     hold_i;
  logic                     cnt_clear_i;
  logic                     v_i;
  logic                     ready_o;
  logic [eaddr_width_p-1:0] eaddr_i;
  logic [1:0]               size_i;
  logic                     store_i;
  logic                     amo_i;
  logic                     lr_i;
  logic                     translation_en_i;
  logic                     page_fault_s1_i;
  logic                     access_fault_s1_i;
  logic                     v_o;
  logic                     exc_v_o;
  logic [3:0]               exc_code_o;
  logic [vaddr_width_p-1:0] vaddr_o;
  logic [cnt_width_p-1:0]   exc_cnt_o;

  modport master (
    output flush_i, hold_i, cnt_clear_i, v_i, eaddr_i, size_i, store_i, amo_i, lr_i,
           translation_en_i, page_fault_s1_i, access_fault_s1_i,
    input  ready_o, v_o, exc_v_o, exc_code_o, vaddr_o, exc_cnt_o
  );

  modport slave (
    input  flush_i, hold_i, cnt_clear_i, v_i, eaddr_i, size_i, store_i, amo_i, lr_i,
           translation_en_i, page_fault_s1_i, access_fault_s1_i,
    output ready_o, v_o, exc_v_o, exc_code_o, vaddr_o, exc_cnt_o
  );
endinterface

// File: rtl/bp_be_mem_fault_pipe.sv
// Exception-staging pipe: early faults (misalign, non-canonical) at stage 0, late TLB/PMA faults merged at stage 1.
// Latency: request accepted at edge N retires on v_o after edge N+stages_p-1; one request per cycle.
// Backpressure: hold_i freezes every stage and the output (ready_o = ~hold_i); flush_i kills everything in flight.
// Ports: clk_i/reset_i (sync, active high) plus the slave side of bp_be_mem_fault_pipe_if.
module bp_be_mem_fault_pipe #(
  parameter int eaddr_width_p     = 64,
  parameter int vaddr_width_p     = 39,
  parameter int stages_p          = 3,
  parameter int misaligned_trap_p = 1,
  parameter int cnt_width_p       = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bp_be_mem_fault_pipe_if.slave  bus
);

  // Stage 0 is the combinational input decode; registers hold stages 1..stages_p-1,
  // and the prioritised result of the last stage is captured in the output register.
  typedef struct packed {
    logic                     v;
    logic                     mis;
    logic                     pf;
    logic                     af;
    logic                     st;     // store-class codes (store, AMO, SC); LR and loads use load codes
    logic [vaddr_width_p-1:0] vaddr;
  } stage_t;

  localparam int   last_lp = stages_p - 1;
  localparam logic trap_lp = (misaligned_trap_p != 0);

  stage_t [stages_p-1:1] stage_q, stage_d, merged;
  stage_t                s0, last;

  logic                     out_v_q, out_v_d;
  logic                     out_exc_q, out_exc_d;
  logic [3:0]               out_code_q, out_code_d;
  logic [vaddr_width_p-1:0] out_vaddr_q, out_vaddr_d;
  logic [cnt_width_p-1:0]   cnt_q, cnt_d;

  logic [2:0] size_mask;
  logic       noncanon;
  logic       inc;

  function automatic logic [3:0] code_f(input stage_t s);
    logic [3:0] c;
    c = 4'd0;
    if (s.mis)     c = s.st ? 4'd6  : 4'd4;
    else if (s.pf) c = s.st ? 4'd15 : 4'd13;
    else if (s.af) c = s.st ? 4'd7  : 4'd5;
    return c;
  endfunction

  assign bus.ready_o = ~bus.hold_i;

  always_comb begin
    case (bus.size_i)
      2'd0:    size_mask = 3'b000;
      2'd1:    size_mask = 3'b001;
      2'd2:    size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase

    noncanon = bus.eaddr_i[eaddr_width_p-1:vaddr_width_p]
               != {(eaddr_width_p-vaddr_width_p){bus.eaddr_i[vaddr_width_p-1]}};

    // Invalid entries carry an all-zero payload so bubbles never raise flags.
    s0 = '0;
    if (bus.v_i) begin
      s0.v     = 1'b1;
      s0.mis   = (bus.amo_i | trap_lp) & (|(bus.eaddr_i[2:0] & size_mask));
      s0.pf    = noncanon & bus.translation_en_i;
      s0.af    = noncanon & ~bus.translation_en_i;
      s0.st    = bus.amo_i ? ~bus.lr_i : bus.store_i;
      s0.vaddr = bus.eaddr_i[vaddr_width_p-1:0];
    end

    merged = stage_q;
    if (stage_q[1].v && !bus.hold_i) begin
      merged[1].pf = stage_q[1].pf | bus.page_fault_s1_i;
      merged[1].af = stage_q[1].af | bus.access_fault_s1_i;
    end
    last = merged[last_lp];

    stage_d     = stage_q;
    out_v_d     = out_v_q;
    out_exc_d   = out_exc_q;
    out_code_d  = out_code_q;
    out_vaddr_d = out_vaddr_q;
    inc         = 1'b0;

    if (bus.flush_i) begin
      stage_d     = '0;
      out_v_d     = 1'b0;
      out_exc_d   = 1'b0;
      out_code_d  = 4'd0;
      out_vaddr_d = '0;
    end else if (!bus.hold_i) begin
      stage_d[1] = s0;
      for (int k = 2; k < stages_p; k++) stage_d[k] = merged[k-1];
      out_v_d     = last.v;
      out_exc_d   = last.mis | last.pf | last.af;
      out_code_d  = code_f(last);
      out_vaddr_d = last.vaddr;
      // Counted only when a faulting request is newly loaded, so a held output counts once.
      inc         = last.mis | last.pf | last.af;
    end

    cnt_d = cnt_q;
    if (bus.cnt_clear_i)         cnt_d = '0;
    else if (inc && !(&cnt_q))   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stage_q     <= '0;
      out_v_q     <= 1'b0;
      out_exc_q   <= 1'b0;
      out_code_q  <= 4'd0;
      out_vaddr_q <= '0;
      cnt_q       <= '0;
    end else begin
      stage_q     <= stage_d;
      out_v_q     <= out_v_d;
      out_exc_q   <= out_exc_d;
      out_code_q  <= out_code_d;
      out_vaddr_q <= out_vaddr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.v_o        = out_v_q;
  assign bus.exc_v_o    = out_exc_q;
  assign bus.exc_code_o = out_code_q;
  assign bus.vaddr_o    = out_vaddr_q;
  assign bus.exc_cnt_o  = cnt_q;

endmodule

// File: tb/tb_bp_be_mem_fault_pipe.sv
// Bench for bp_be_mem_fault_pipe: three instances (default, no-misalign-trap with 2-bit counter, two stages).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit after the edge.
// Backpressure: hold/flush exercised on the default instance; shared stimulus drives all instances.
module tb_bp_be_mem_fault_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, hold, clr, v, store, amo, lr, ten, pf, af;
  logic [63:0] ea;
  logic [1:0]  size;
  int checks = 0;
  int passed = 0;

  bp_be_mem_fault_pipe_if #(.eaddr_width_p(64), .vaddr_width_p(39), .cnt_width_p(16)) ifa ();
  bp_be_mem_fault_pipe_if #(.eaddr_width_p(64), .vaddr_width_p(39), .cnt_width_p(2))  ifb ();
  bp_be_mem_fault_pipe_if #(.eaddr_width_p(64), .vaddr_width_p(39), .cnt_width_p(16)) ifc ();

  assign ifa.flush_i = flush;  assign ifb.flush_i = flush;  assign ifc.flush_i = flush;
  assign ifa.hold_i = hold;    assign ifb.hold_i = hold;    assign ifc.hold_i = hold;
  assign ifa.cnt_clear_i = clr; assign ifb.cnt_clear_i = clr; assign ifc.cnt_clear_i = clr;
  assign ifa.v_i = v;          assign ifb.v_i = v;          assign ifc.v_i = v;
  assign ifa.eaddr_i = ea;     assign ifb.eaddr_i = ea;     assign ifc.eaddr_i = ea;
  assign ifa.size_i = size;    assign ifb.size_i = size;    assign ifc.size_i = size;
  assign ifa.store_i = store;  assign ifb.store_i = store;  assign ifc.store_i = store;
  assign ifa.amo_i = amo;      assign ifb.amo_i = amo;      assign ifc.amo_i = amo;
  assign ifa.lr_i = lr;        assign ifb.lr_i = lr;        assign ifc.lr_i = lr;
  assign ifa.translation_en_i = ten;  assign ifb.translation_en_i = ten;  assign ifc.translation_en_i = ten;
  assign ifa.page_fault_s1_i = pf;    assign ifb.page_fault_s1_i = pf;    assign ifc.page_fault_s1_i = pf;
  assign ifa.access_fault_s1_i = af;  assign ifb.access_fault_s1_i = af;  assign ifc.access_fault_s1_i = af;

  bp_be_mem_fault_pipe #(.eaddr_width_p(64), .vaddr_width_p(39), .stages_p(3),
                         .misaligned_trap_p(1), .cnt_width_p(16))
    dut_a (.clk_i(clk), .reset_i(reset), .bus(ifa));
  bp_be_mem_fault_pipe #(.eaddr_width_p(64), .vaddr_width_p(39), .stages_p(3),
                         .misaligned_trap_p(0), .cnt_width_p(2))
    dut_b (.clk_i(clk), .reset_i(reset), .bus(ifb));
  bp_be_mem_fault_pipe #(.eaddr_width_p(64), .vaddr_width_p(39), .stages_p(2),
                         .misaligned_trap_p(1), .cnt_width_p(16))
    dut_c (.clk_i(clk), .reset_i(reset), .bus(ifc));

  // Reference: RISC-V exception code straight from the access description.
  function automatic logic [3:0] ref_code(input logic [63:0] a, input logic [1:0] sz,
                                          input logic st, input logic am, input logic l,
                                          input logic tn, input logic p, input logic f, input bit trap);
    longint unsigned nbytes;
    logic [63:0] top;
    bit mis, nc, is_st, pff, aff;
    nbytes = 64'd1 << sz;
    mis    = ((a % nbytes) != 0) && (am || trap);
    top    = a >> 38;                              // bits 63..38 must all agree
    nc     = !(top == 64'd0 || top == 64'h3ff_ffff);
    is_st  = am ? !l : st;
    pff    = p || (nc && tn);
    aff    = f || (nc && !tn);
    if (mis) return is_st ? 4'd6 : 4'd4;
    if (pff) return is_st ? 4'd15 : 4'd13;
    if (aff) return is_st ? 4'd7 : 4'd5;
    return 4'd0;
  endfunction

  task automatic idle_inputs();
    flush = 0; hold = 0; clr = 0; v = 0; store = 0; amo = 0; lr = 0; ten = 0;
    pf = 0; af = 0; ea = 64'd0; size = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One isolated request; returns 1 unit after the edge where the 3-stage instances retire it.
  task automatic send(input logic [63:0] a, input logic [1:0] sz, input logic st, input logic am,
                      input logic l, input logic tn, input logic lpf, input logic laf, input logic clr_at_retire);
    v = 1; ea = a; size = sz; store = st; amo = am; lr = l; ten = tn;
    @(posedge clk); #1;
    v = 0; pf = lpf; af = laf;
    @(posedge clk); #1;
    pf = 0; af = 0; clr = clr_at_retire;
    @(posedge clk); #1;
    clr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifa.v_o !== 1'b0) $display("FAIL reset_v_o: got %b want 0", ifa.v_o); else passed++;
    checks++; if (ifa.exc_v_o !== 1'b0) $display("FAIL reset_exc_v_o: got %b want 0", ifa.exc_v_o); else passed++;
    checks++; if (ifa.exc_code_o !== 4'd0) $display("FAIL reset_exc_code: got %0d want 0", ifa.exc_code_o); else passed++;
    checks++; if (ifa.vaddr_o !== 39'd0) $display("FAIL reset_vaddr: got %h want 0", ifa.vaddr_o); else passed++;
    checks++; if (ifa.exc_cnt_o !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", ifa.exc_cnt_o); else passed++;
    checks++; if (ifc.v_o !== 1'b0) $display("FAIL reset_c_v_o: got %b want 0", ifc.v_o); else passed++;
    hold = 1; #1;
    checks++; if (ifa.ready_o !== 1'b0) $display("FAIL ready_hold: got %b want 0", ifa.ready_o); else passed++;
    hold = 0; #1;
    checks++; if (ifa.ready_o !== 1'b1) $display("FAIL ready_nohold: got %b want 1", ifa.ready_o); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_fault_codes();
    logic [63:0] t_ea [7];
    logic [1:0]  t_sz [7];
    logic        t_st [7], t_amo [7], t_ten [7], t_pf [7], t_af [7];
    logic [3:0]  xa [7], xb [7];
    logic [38:0] xva [7];
    t_ea  = '{64'h1004, 64'h2000, 64'h2000, 64'h80_0000_0000, 64'h80_0000_0000, 64'h1001, 64'h1001};
    t_sz  = '{2'd3, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd3};
    t_st  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t_amo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    t_ten = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    t_pf  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    t_af  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    xa    = '{4'd4, 4'd15, 4'd7, 4'd13, 4'd5, 4'd4, 4'd6};
    xb    = '{4'd0, 4'd15, 4'd7, 4'd13, 4'd5, 4'd0, 4'd6};
    xva   = '{39'h1004, 39'h2000, 39'h2000, 39'h0, 39'h0, 39'h1001, 39'h1001};
    for (int i = 0; i < 7; i++) begin
      send(t_ea[i], t_sz[i], t_st[i], t_amo[i], 1'b0, t_ten[i], t_pf[i], t_af[i], 1'b0);
      checks++; if (ifa.v_o !== 1'b1) $display("FAIL codes%0d_a_v_o: got %b want 1", i, ifa.v_o); else passed++;
      checks++; if (ifa.exc_v_o !== (xa[i] != 0)) $display("FAIL codes%0d_a_exc_v: got %b want %b", i, ifa.exc_v_o, xa[i] != 0); else passed++;
      checks++; if (ifa.exc_code_o !== xa[i]) $display("FAIL codes%0d_a_code: got %0d want %0d", i, ifa.exc_code_o, xa[i]); else passed++;
      checks++; if (ifa.vaddr_o !== xva[i]) $display("FAIL codes%0d_a_vaddr: got %h want %h", i, ifa.vaddr_o, xva[i]); else passed++;
      checks++; if (ifb.exc_v_o !== (xb[i] != 0)) $display("FAIL codes%0d_b_exc_v: got %b want %b", i, ifb.exc_v_o, xb[i] != 0); else passed++;
      checks++; if (ifb.exc_code_o !== xb[i]) $display("FAIL codes%0d_b_code: got %0d want %0d", i, ifb.exc_code_o, xb[i]); else passed++;
      if (i == 0) begin
        checks++; if (ifa.exc_cnt_o !== 16'd1) $display("FAIL codes_first_cnt: got %0d want 1", ifa.exc_cnt_o); else passed++;
      end
    end
    checks++; if (ifa.exc_cnt_o !== 16'd7) $display("FAIL codes_cnt_a: got %0d want 7", ifa.exc_cnt_o); else passed++;
    checks++; if (ifb.exc_cnt_o !== 2'd3) $display("FAIL codes_cnt_b_sat: got %0d want 3", ifb.exc_cnt_o); else passed++;
  endtask

  task automatic test_clear_coincide();
    send(64'h1001, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (ifa.exc_code_o !== 4'd6) $display("FAIL clear_code: got %0d want 6", ifa.exc_code_o); else passed++;
    checks++; if (ifa.exc_cnt_o !== 16'd0) $display("FAIL clear_cnt_a: got %0d want 0", ifa.exc_cnt_o); else passed++;
    checks++; if (ifb.exc_cnt_o !== 2'd0) $display("FAIL clear_cnt_b: got %0d want 0", ifb.exc_cnt_o); else passed++;
    send(64'h2000, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (ifa.exc_cnt_o !== 16'd1) $display("FAIL clear_after_cnt_a: got %0d want 1", ifa.exc_cnt_o); else passed++;
    checks++; if (ifb.exc_cnt_o !== 2'd1) $display("FAIL clear_after_cnt_b: got %0d want 1", ifb.exc_cnt_o); else passed++;
  endtask

  // R1 store+late pf, R2 misaligned D load, R3 non-canonical load; hold on edges 3-4, flush on edge 6 with R4.
  task automatic test_back_to_back_hold_flush();
    logic        s_v [9], s_h [9], s_f [9], s_st [9], s_tn [9], s_pf [9];
    logic [1:0]  s_sz [9];
    logic [63:0] s_ea [9];
    logic        x_v [7];
    logic [3:0]  x_c [7];
    logic [15:0] x_n [7];
    logic [38:0] x_a [7];
    s_v  = '{1, 1, 1, 1, 1, 0, 1, 0, 0};
    s_h  = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    s_f  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    s_st = '{1, 0, 0, 1, 1, 0, 1, 0, 0};
    s_tn = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    s_pf = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    s_sz = '{2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0};
    s_ea = '{64'h2000, 64'h1004, 64'h80_0000_0000, 64'h3001, 64'h3001, 64'h0, 64'h5002, 64'h0, 64'h0};
    x_v  = '{1, 1, 1, 1, 0, 0, 0};
    x_c  = '{4'd15, 4'd15, 4'd15, 4'd4, 4'd0, 4'd0, 4'd0};
    x_n  = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2};
    x_a  = '{39'h2000, 39'h2000, 39'h2000, 39'h1004, 39'h0, 39'h0, 39'h0};
    do_reset();
    for (int e = 0; e < 9; e++) begin
      v = s_v[e]; hold = s_h[e]; flush = s_f[e]; store = s_st[e]; ten = s_tn[e];
      pf = s_pf[e]; size = s_sz[e]; ea = s_ea[e];
      #1;
      checks++; if (ifa.ready_o !== !s_h[e]) $display("FAIL b2b_ready%0d: got %b want %b", e, ifa.ready_o, !s_h[e]); else passed++;
      @(posedge clk); #1;
      if (e >= 2) begin
        checks++; if (ifa.v_o !== x_v[e-2]) $display("FAIL b2b_v_o%0d: got %b want %b", e, ifa.v_o, x_v[e-2]); else passed++;
        checks++; if (ifa.exc_code_o !== x_c[e-2]) $display("FAIL b2b_code%0d: got %0d want %0d", e, ifa.exc_code_o, x_c[e-2]); else passed++;
        checks++; if (ifa.exc_cnt_o !== x_n[e-2]) $display("FAIL b2b_cnt%0d: got %0d want %0d", e, ifa.exc_cnt_o, x_n[e-2]); else passed++;
        checks++; if (ifa.vaddr_o !== x_a[e-2]) $display("FAIL b2b_vaddr%0d: got %h want %h", e, ifa.vaddr_o, x_a[e-2]); else passed++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    send(64'h2000, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1; hold = 1; flush = 1; v = 1; ea = 64'h1001; size = 2'd3;
    @(posedge clk); #1;
    checks++; if (ifa.v_o !== 1'b0) $display("FAIL midreset_v_o: got %b want 0", ifa.v_o); else passed++;
    checks++; if (ifa.exc_code_o !== 4'd0) $display("FAIL midreset_code: got %0d want 0", ifa.exc_code_o); else passed++;
    checks++; if (ifa.exc_cnt_o !== 16'd0) $display("FAIL midreset_cnt: got %0d want 0", ifa.exc_cnt_o); else passed++;
    reset = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ifa.v_o !== 1'b0) $display("FAIL midreset_drained: got %b want 0", ifa.v_o); else passed++;
  endtask

  task automatic test_random_stream();
    localparam int N = 400;
    logic        r_v [N], r_st [N], r_amo [N], r_lr [N], r_tn [N], r_pf [N], r_af [N];
    logic [1:0]  r_sz [N];
    logic [63:0] r_ea [N];
    logic [3:0]  r_ca [N], r_cb [N];
    logic        r_clr [N+2];
    int          lat [3], m_cnt [3], m_max [3];
    logic        ov [3], oe [3];
    logic [3:0]  oc [3];
    logic [38:0] oa [3];
    int          on [3];
    lat = '{2, 2, 1};
    m_max = '{65535, 3, 65535};
    m_cnt = '{0, 0, 0};
    for (int i = 0; i < N; i++) begin
      r_v[i] = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: r_ea[i] = 64'h1000 + 64'($urandom_range(0, 255));
        1: r_ea[i] = {$urandom, $urandom};
        2: r_ea[i] = {26'h3ff_ffff, 38'({$urandom, $urandom})};
        default: r_ea[i] = {26'h0, 38'({$urandom, $urandom})};
      endcase
      r_sz[i] = 2'($urandom_range(0, 3));
      r_st[i] = 1'($urandom); r_amo[i] = ($urandom_range(0, 3) == 0); r_lr[i] = 1'($urandom);
      r_tn[i] = 1'($urandom); r_pf[i] = ($urandom_range(0, 5) == 0); r_af[i] = ($urandom_range(0, 5) == 0);
      r_ca[i] = r_v[i] ? ref_code(r_ea[i], r_sz[i], r_st[i], r_amo[i], r_lr[i], r_tn[i], r_pf[i], r_af[i], 1'b1) : 4'd0;
      r_cb[i] = r_v[i] ? ref_code(r_ea[i], r_sz[i], r_st[i], r_amo[i], r_lr[i], r_tn[i], r_pf[i], r_af[i], 1'b0) : 4'd0;
    end
    for (int e = 0; e < N + 2; e++) r_clr[e] = ($urandom_range(0, 19) == 0);
    do_reset();
    for (int e = 0; e < N + 2; e++) begin
      if (e < N) begin
        v = r_v[e]; ea = r_ea[e]; size = r_sz[e]; store = r_st[e]; amo = r_amo[e]; lr = r_lr[e]; ten = r_tn[e];
      end else begin
        v = 0;
      end
      pf = (e >= 1 && e - 1 < N) ? r_pf[e-1] : 1'b0;
      af = (e >= 1 && e - 1 < N) ? r_af[e-1] : 1'b0;
      clr = r_clr[e];
      @(posedge clk); #1;
      ov = '{ifa.v_o, ifb.v_o, ifc.v_o};
      oe = '{ifa.exc_v_o, ifb.exc_v_o, ifc.exc_v_o};
      oc = '{ifa.exc_code_o, ifb.exc_code_o, ifc.exc_code_o};
      oa = '{ifa.vaddr_o, ifb.vaddr_o, ifc.vaddr_o};
      on = '{int'(ifa.exc_cnt_o), int'(ifb.exc_cnt_o), int'(ifc.exc_cnt_o)};
      for (int d = 0; d < 3; d++) begin
        int idx;
        logic xv;
        logic [3:0] xc;
        idx = e - lat[d];
        xv = (idx >= 0 && idx < N) ? r_v[idx] : 1'b0;
        xc = !xv ? 4'd0 : (d == 1) ? r_cb[idx] : r_ca[idx];
        if (r_clr[e]) m_cnt[d] = 0;
        else if (xc != 0 && m_cnt[d] < m_max[d]) m_cnt[d]++;
        checks++; if (ov[d] !== xv) $display("FAIL rnd_v_o dut%0d e%0d: got %b want %b", d, e, ov[d], xv); else passed++;
        checks++; if (oe[d] !== (xc != 0)) $display("FAIL rnd_exc_v dut%0d e%0d: got %b want %b", d, e, oe[d], xc != 0); else passed++;
        checks++; if (oc[d] !== xc) $display("FAIL rnd_code dut%0d e%0d: got %0d want %0d", d, e, oc[d], xc); else passed++;
        checks++; if (on[d] != m_cnt[d]) $display("FAIL rnd_cnt dut%0d e%0d: got %0d want %0d", d, e, on[d], m_cnt[d]); else passed++;
        if (xv) begin
          checks++; if (oa[d] !== r_ea[idx][38:0]) $display("FAIL rnd_vaddr dut%0d e%0d: got %h want %h", d, e, oa[d], r_ea[idx][38:0]); else passed++;
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_fault_codes();
    test_clear_coincide();
    test_back_to_back_hold_flush();
    test_mid_reset();
    test_random_stream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/bp_be_mem_fault_pipe.md
Name: bp_be_mem_fault_pipe

Overview:
Parametrised exception-staging pipeline for the BE memory pipe. It accepts one memory request per cycle and detects early faults at stage 0: address misalignment and non-canonical effective address. Late faults from the D-TLB/PMA stage (page and access faults) are merged at stage 1. All faults are carried through stages_p stages and retire as one prioritised RISC-V exception code, aligned with the D$ miss/early-data stage. Misalignment detection is configurable per access class, and the pipe supports hold, flush and a saturating exception counter.

Parameters:
eaddr_width_p, 64, effective-address width from rs1+imm
vaddr_width_p, 39, canonical virtual-address width; requires vaddr_width_p < eaddr_width_p
stages_p, 3, pipeline depth, stage 0 to output; legal range 2..8
misaligned_trap_p, 1, 1: misaligned load/store traps; 0: only AMO/LR/SC misalignment traps
cnt_width_p, 16, width of the exception counter

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
flush_i  in  1  kill all in-flight requests and any request on v_i this cycle
hold_i  in  1  freeze all stages
v_i  in  1  request valid at stage 0
ready_o  out  1  request accepted when v_i & ready_o; equals ~hold_i
eaddr_i  in  eaddr_width_p  effective address
size_i  in  2  access size: 0=B, 1=H, 2=W, 3=D
store_i  in  1  store access
amo_i  in  1  AMO/LR/SC access (uses store codes, except LR uses load codes)
lr_i  in  1  LR (with amo_i)
translation_en_i  in  1  translation enabled, sampled at stage 0
page_fault_s1_i  in  1  TLB/permission fault for the stage-1 request
access_fault_s1_i  in  1  PMA/domain fault for the stage-1 request
v_o  out  1  a request retires at stage stages_p-1
exc_v_o  out  1  retiring request has an exception
exc_code_o  out  4  mcause code
vaddr_o  out  vaddr_width_p  retiring address, low vaddr_width_p bits
exc_cnt_o  out  cnt_width_p  saturating count of retired exceptions
cnt_clear_i  in  1  zero exc_cnt_o

Behaviour:
- Reset: every stage-valid bit is 0 and all stage payloads are 0. v_o=0, exc_v_o=0, exc_code_o=0, vaddr_o=0, exc_cnt_o=0. ready_o follows hold_i combinationally.
- Stage 0, combinational on accepted input:
  - Misaligned: eaddr_i low bits are nonzero under the size mask (H: bit0; W: bits1:0; D: bits2:0).
  - Misalignment is gated by (amo_i | misaligned_trap_p).
  - Non-canonical: eaddr_i[eaddr_width_p-1:vaddr_width_p] != replicated eaddr_i[vaddr_width_p-1].
- Stage advance: on each edge with ~hold_i & ~flush_i, stage k+1 takes stage k and stage 0 takes the input (valid = v_i).
- Stage 1 merge: page_fault_s1_i and access_fault_s1_i are OR-ed into stage 1 only when stage 1 is valid and ~hold_i. They are latched into stage 2 on advance; for stages_p=2 they are latched into the output register.
- Non-canonical address: sets the page-fault flag when the sampled translation_en is 1, otherwise the access-fault flag.
- Output priority, evaluated at the last stage:
  - misaligned > page > access.
  - store/AMO (non-LR): 6 / 15 / 7.
  - load/LR: 4 / 13 / 5.
  - exc_v_o = v_o & any flag; exc_code_o = 0 when ~exc_v_o.
- Latency: a request accepted at edge N appears on v_o after edge N+stages_p-1, absent hold.
- hold_i: all stages and outputs keep their value; v_i is ignored. A held output still presents v_o, but it is counted only once.
- flush_i: on the next edge all valid bits clear, including the stage receiving v_i. flush beats hold. Outputs go to 0 the cycle after flush.
- Counter: increments on each retirement where v_o & exc_v_o becomes newly valid (one count per request) and saturates at all-ones. cnt_clear_i zeroes it. If clear and increment coincide, the result is 0.
- reset_i mid-operation: identical to the reset state on the next edge; reset beats flush and hold.
- Only late-fault inputs with a valid stage 1 have effect.

Test Plan:
- stages_p=3: D load, eaddr=0x1004, no faults -> v_o two cycles later, exc_v_o=1, exc_code_o=4, vaddr_o=0x1004, exc_cnt_o=1.
- W store, eaddr=0x2000, page_fault_s1_i=1 and access_fault_s1_i=1 -> exc_code_o=15. Same with page_fault_s1_i=0 -> exc_code_o=7.
- translation_en_i=1 load, eaddr=0x0000_0080_0000_0000 (vaddr_width_p=39) -> exc_code_o=13. With translation_en_i=0 -> exc_code_o=5.
- misaligned_trap_p=0: H load at 0x1001 -> exc_v_o=0. AMO D at 0x1001 -> exc_code_o=6.
- Back-to-back 3 requests; hold_i for 2 cycles mid-stream; flush_i on the 4th issue cycle -> 1st two retire in order with each output stable during hold; remaining requests never appear on v_o.
- cnt_width_p=2: 5 faulting requests -> exc_cnt_o saturates at 3. cnt_clear_i pulsed together with a retiring fault -> exc_cnt_o=0.
